scan_decoder: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable.
- Generalises the 2-to-4 enable decoder in select width and output polarity.
- Adds a self-timed scan mode that steps the active output through every line with a programmable dwell time, e.g. for multiplexed display digit strobes or round-robin channel select.
- Sits between control logic and multiplexed output drivers.

---
 rtl/scan_decoder_pkg.sv | 16 +
 rtl/scan_decoder_onehot_dec.sv | 26 ++
 rtl/scan_decoder.sv | 120 ++++++++++++
 tb/tb_scan_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan_decoder block.
// Holds the FSM state type and the mode select encodings used by the top.
// ST_BLANK is always declared. It is only reached when SCAN_DECODER_BLANK_EN is defined.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: combinational SEL_W -> 2**SEL_W one-hot decoder with enable.
// Ports:
//   en  - 1 selects line `sel`; 0 drives all lines inactive
//   sel - line index to activate
//   out - decoded lines; active level is OUT_POL, inactive level is ~OUT_POL
module onehot_dec #(
  parameter int unsigned SEL_W   = 2,
  parameter bit          OUT_POL = 1'b1
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   out
);

  localparam int unsigned NOUT = 2**SEL_W;

  always_comb begin
    out = OUT_POL ? '0 : '1;
    for (int unsigned i = 0; i < NOUT; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        out[i] = OUT_POL;
      end
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with enable and a
// self-timed scan mode that steps through every line with a programmable dwell.
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst   - synchronous active-high reset; overrides every other input
//   en    - 0 forces all outputs inactive (IDLE)
//   mode  - 0 = DIRECT (decode sel), 1 = SCAN (internal index)
//   sel   - line to activate in DIRECT mode
//   dwell - cycles per scan step minus 1; sampled every cycle
//   out   - registered one-hot lines, polarity set by OUT_POL
//   idx   - index of the currently or last active line
//   step  - one-cycle pulse when the scan index advances
//   wrap  - one-cycle pulse when the scan index wraps from NOUT-1 to 0
// Build option: define SCAN_DECODER_BLANK_EN to insert one all-inactive
// BLANK cycle on every scan advance.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8,
  parameter bit          OUT_POL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**SEL_W-1:0]  out,
  output logic [SEL_W-1:0]     idx,
  output logic                 step,
  output logic                 wrap
);

  localparam int unsigned NOUT = 2**SEL_W;

  state_e               state_q, state_d;
  logic [NOUT-1:0]      out_q, out_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 step_q, step_d;
  logic                 wrap_q, wrap_d;
  logic                 dec_en;

  // The decoder always looks at the next index. Each state only has to
  // decide whether a line is shown in the next cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    dec_en  = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
    end else if (mode == MODE_DIRECT) begin
      state_d = ST_DIRECT;
      idx_d   = sel;
      dec_en  = 1'b1;
    end else begin
      state_d = ST_SCAN;
      dec_en  = 1'b1;
      if (state_q == ST_SCAN) begin
        if (cnt_q >= dwell) begin
          idx_d  = idx_q + SEL_W'(1);
          step_d = 1'b1;
          wrap_d = (idx_q == '1);
`ifdef SCAN_DECODER_BLANK_EN
          state_d = ST_BLANK;
          dec_en  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
`ifdef SCAN_DECODER_BLANK_EN
      end else if (state_q == ST_BLANK) begin
        // The index already advanced on entry to BLANK. Show it now, with
        // cnt restarting at 0.
        idx_d = idx_q;
`endif
      end else begin
        idx_d = '0;
      end
    end
  end

  onehot_dec #(
    .SEL_W   (SEL_W),
    .OUT_POL (OUT_POL)
  ) u_dec (
    .en  (dec_en),
    .sel (idx_d),
    .out (out_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= OUT_POL ? '0 : '1;
      idx_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=2, DWELL_W=8).
// A second instance is built with OUT_POL=0 to cover active-low outputs.
// Expectations follow SCAN_DECODER_BLANK_EN when it is defined.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [1:0] sel;
  logic [7:0] dwell;
  logic [3:0] out, out_n;
  logic [1:0] idx, idx_n;
  logic       step, wrap, step_n, wrap_n;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .DWELL_W(8), .OUT_POL(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .out(out), .idx(idx), .step(step), .wrap(wrap)
  );

  scan_decoder #(.SEL_W(2), .DWELL_W(8), .OUT_POL(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .out(out_n), .idx(idx_n), .step(step_n), .wrap(wrap_n)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected scan behaviour from the entry cycle (i = 0) onward for a constant dwell d.
  task automatic scan_run(input int d, input int n);
    int seg, pos, line;
    for (int i = 0; i < n; i++) begin
      tick();
`ifdef SCAN_DECODER_BLANK_EN
      seg = i / (d + 2);
      pos = i % (d + 2);
      if (pos == d + 1) begin
        line = (seg + 1) % 4;
        chk("scan_out", out, 0);
        chk("scan_idx", idx, line);
        chk("scan_step", step, 1);
        chk("scan_wrap", wrap, (line == 0) ? 1 : 0);
      end else begin
        line = seg % 4;
        chk("scan_out", out, 1 << line);
        chk("scan_idx", idx, line);
        chk("scan_step", step, 0);
        chk("scan_wrap", wrap, 0);
      end
`else
      seg  = i / (d + 1);
      pos  = i % (d + 1);
      line = seg % 4;
      chk("scan_out", out, 1 << line);
      chk("scan_idx", idx, line);
      chk("scan_step", step, (i > 0 && pos == 0) ? 1 : 0);
      chk("scan_wrap", wrap, (i > 0 && pos == 0 && line == 0) ? 1 : 0);
`endif
      chk("onehot", ($countones(out) <= 1) ? 1 : 0, 1);
    end
  endtask

  logic [3:0] seq6 [7];

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0; dwell = 8'd0;

    // Reset takes priority over a scan request.
    tick(); tick();
    chk("rst_out", out, 4'b0000);
    chk("rst_idx", idx, 0);
    chk("rst_step", step, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_out_n", out_n, 4'b1111);

    // DIRECT decode.
    rst = 1'b0; mode = 1'b0; sel = 2'd2;
    tick();
    chk("dir_sel2", out, 4'b0100);
    chk("dir_idx2", idx, 2);
    sel = 2'd3;
    tick();
    chk("dir_sel3", out, 4'b1000);
    en = 1'b0;
    tick();
    chk("dis_out", out, 4'b0000);
    chk("dis_idx", idx, 3);
    chk("dis_out_n", out_n, 4'b1111);
    en = 1'b1; sel = 2'd0;
    tick();
    chk("dir_sel0", out, 4'b0001);
    chk("dir_sel0_n", out_n, 4'b1110);

    // SCAN with dwell = 2, entered from DIRECT.
    mode = 1'b1; dwell = 8'd2;
    scan_run(2, 13);

    // Leaving SCAN for DIRECT.
    mode = 1'b0; sel = 2'd1;
    tick();
    chk("scan2dir_out", out, 4'b0010);
    chk("scan2dir_idx", idx, 1);
    chk("scan2dir_step", step, 0);

    // SCAN with dwell = 0.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1; dwell = 8'd0;
    scan_run(0, 9);

    // Lowering dwell below cnt advances on the next edge.
    en = 1'b0; tick();
    en = 1'b1; dwell = 8'd7;
    scan_run(7, 4);
    dwell = 8'd2;
    tick();
`ifdef SCAN_DECODER_BLANK_EN
    chk("lower_out", out, 4'b0000);
`else
    chk("lower_out", out, 4'b0010);
`endif
    chk("lower_idx", idx, 1);
    chk("lower_step", step, 1);

    // Raising dwell to 5 when cnt = 3: two more holding cycles, then advance.
    en = 1'b0; tick();
    en = 1'b1; dwell = 8'd7;
    scan_run(7, 4);
    dwell = 8'd5;
    tick();
    chk("raise_hold1", out, 4'b0001);
    chk("raise_step1", step, 0);
    tick();
    chk("raise_hold2", out, 4'b0001);
    tick();
`ifdef SCAN_DECODER_BLANK_EN
    chk("raise_adv", out, 4'b0000);
`else
    chk("raise_adv", out, 4'b0010);
`endif
    chk("raise_idx", idx, 1);
    chk("raise_step", step, 1);

    // Reset mid-scan at idx = 2, then restart.
    en = 1'b0; tick();
    en = 1'b1; dwell = 8'd0;
`ifdef SCAN_DECODER_BLANK_EN
    scan_run(0, 4);
`else
    scan_run(0, 3);
`endif
    chk("pre_rst_idx", idx, 2);
    rst = 1'b1;
    tick();
    chk("midrst_out", out, 4'b0000);
    chk("midrst_idx", idx, 0);
    chk("midrst_step", step, 0);
    chk("midrst_out_n", out_n, 4'b1111);
    rst = 1'b0;
    tick();
    chk("restart_out", out, 4'b0001);
    chk("restart_idx", idx, 0);
    chk("restart_step", step, 0);

    // Directed dwell = 1 sequence.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1; dwell = 8'd1;
`ifdef SCAN_DECODER_BLANK_EN
    seq6 = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
`else
    seq6 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
`endif
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("dwell1_%0d", k), out, seq6[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
